product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter WIDTH, default 16, SHALL be the multiplier operand width; products are 2*WIDTH bits.
REQ-002 Parameter ACC_WIDTH, default 40, SHALL be the accumulator/sum width; legal range ACC_WIDTH >= 2*WIDTH.
REQ-003 Parameter COUNT, default 8, SHALL be the number of products summed per frame; legal range 2..65535.
REQ-004 Clocking SHALL be one clock with asynchronous, active-low reset.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-007 p  input  2*WIDTH  SHALL carry the unsigned registered product from the upstream multiplier.
REQ-008 in_valid  input  1  SHALL mark p as valid this cycle.
REQ-009 in_ready  output  1  SHALL indicate the block accepts p this cycle.
REQ-010 clear  input  1  SHALL synchronously abort the current frame.
REQ-011 sum  output  ACC_WIDTH  SHALL carry the completed frame sum.
REQ-012 ovf  output  1  SHALL flag that the frame sum saturated.
REQ-013 out_valid  output  1  SHALL mark sum/ovf as valid.
REQ-014 out_ready  input  1  SHALL indicate the downstream consumer takes sum this cycle.

Function
REQ-015 The block SHALL implement a two-state FSM: ACC (collecting) and HOLD (result pending).
REQ-016 In ACC, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-017 Acceptance SHALL occur only when in_valid and in_ready are both 1 on a rising edge.
REQ-018 On acceptance, acc SHALL become acc + zero-extended p, and the sample counter SHALL increment.
REQ-019 Overflow beyond ACC_WIDTH bits SHALL saturate acc to all-ones and set a sticky per-frame overflow bit.
REQ-020 On the COUNT-th acceptance, the edge SHALL load sum with the (saturated) acc + p, load ovf, clear acc, counter and sticky bit, and enter HOLD.
REQ-021 Latency SHALL be one cycle: out_valid asserts the cycle after the final accepting edge.
REQ-022 In HOLD, sum and ovf SHALL stay stable while out_ready is 0.
REQ-023 In HOLD with out_ready 1, the block SHALL return to ACC on that edge, with out_valid 0 the next cycle.
REQ-024 The counter SHALL wrap from COUNT-1 to 0 only via the HOLD transition, never via free-running overflow.
REQ-025 clear=1 SHALL have priority over all other inputs: enter ACC, zero acc/counter/sticky bit, deassert out_valid, and ignore any coincident p.
REQ-026 clear SHALL leave sum and ovf register values unchanged; they are don't-care while out_valid is 0.
REQ-027 in_valid 0 cycles SHALL not change acc or the counter (bubbles allowed).
REQ-028 out_ready asserted in ACC SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately, independent of clk, force ACC, acc=0, counter=0, sticky=0, sum=0, ovf=0, out_valid=0, in_ready=1.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard partial and pending results; the first accepted product after release starts a new frame.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-032 COUNT=4, products 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 4th acceptance, sum=10, ovf=0, then out_valid=0 and in_ready=1.
REQ-033 Same frame with bubbles between products and out_ready held 0 for 3 cycles -> sum=10 stable for 4 cycles, in_ready=0 throughout HOLD, release on out_ready.
REQ-034 WIDTH=16, ACC_WIDTH=32, COUNT=2, products 0xFFFF0001 twice -> sum=0xFFFFFFFF, ovf=1; next frame of 1,1 -> sum=2, ovf=0.
REQ-035 COUNT=4, after 2 products (5,5) assert clear with in_valid=1, p=7 -> p ignored; following 1,1,1,1 -> sum=4.
REQ-036 rst_n pulsed low mid-frame and again during HOLD -> outputs at reset values with no clk edge; next 4 products 2,2,2,2 -> sum=8.
REQ-037 Back-to-back frames, COUNT=4, in_valid held high -> exactly one out_valid per 4 acceptances, with no product lost or double-counted.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the upstream multiplier, the product accumulator
// and the downstream sum consumer.
interface product_accumulator_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
);
    logic [2*WIDTH-1:0]   p;
    logic                 in_valid;
    logic                 in_ready;
    logic                 clear;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output p, in_valid, clear, out_ready,
        input  in_ready, sum, ovf, out_valid
    );

    modport slave (
        input  p, in_valid, clear, out_ready,
        output in_ready, sum, ovf, out_valid
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned products per frame with saturation and a sticky overflow
// flag, then holds the frame result until the consumer takes it.
module product_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int COUNT     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    product_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(COUNT);
    localparam int SUM_W = ACC_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_r, state_s;
    logic [ACC_WIDTH-1:0] acc_r, acc_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 sticky_r, sticky_s;
    logic [ACC_WIDTH-1:0] sum_r, sum_s;
    logic                 ovf_r, ovf_s;
    logic [ACC_WIDTH-1:0] add_s;
    logic                 carry_s;

    // Returns {carry, value}; value pins to all-ones whenever the add carries out.
    function automatic logic [SUM_W-1:0] sat_add(
        input logic [ACC_WIDTH-1:0] a,
        input logic [2*WIDTH-1:0]   b
    );
        logic [SUM_W-1:0] raw;
        raw = {1'b0, a} + SUM_W'(b);
        if (raw[ACC_WIDTH]) begin
            sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
        end else begin
            sat_add = raw;
        end
    endfunction

    // Next-state and datapath update; clear overrides every other input.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        sticky_s = sticky_r;
        sum_s    = sum_r;
        ovf_s    = ovf_r;
        {carry_s, add_s} = sat_add(acc_r, bus.p);

        if (bus.clear) begin
            state_s  = ST_ACC;
            acc_s    = {ACC_WIDTH{1'b0}};
            cnt_s    = {CNT_W{1'b0}};
            sticky_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        if (cnt_r == CNT_W'(COUNT - 1)) begin
                            sum_s    = add_s;
                            ovf_s    = sticky_r | carry_s;
                            acc_s    = {ACC_WIDTH{1'b0}};
                            cnt_s    = {CNT_W{1'b0}};
                            sticky_s = 1'b0;
                            state_s  = ST_HOLD;
                        end else begin
                            acc_s    = add_s;
                            cnt_s    = cnt_r + CNT_W'(1);
                            sticky_s = sticky_r | carry_s;
                        end
                    end else begin
                        acc_s = acc_r;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_s = ST_ACC;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_ACC;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_ACC;
            acc_r    <= {ACC_WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            sticky_r <= 1'b0;
            sum_r    <= {ACC_WIDTH{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            sticky_r <= sticky_s;
            sum_r    <= sum_s;
            ovf_r    <= ovf_s;
        end
    end

    assign bus.in_ready  = (state_r == ST_ACC);
    assign bus.out_valid = (state_r == ST_HOLD);
    assign bus.sum       = sum_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a COUNT=4/ACC_WIDTH=40 instance and a
// COUNT=2/ACC_WIDTH=32 instance checked against a frame-sum reference model.
module tb_product_accumulator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    product_accumulator_if #(.WIDTH(16), .ACC_WIDTH(40)) bus4 ();
    product_accumulator_if #(.WIDTH(16), .ACC_WIDTH(32)) bus2 ();

    product_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .COUNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));
    product_accumulator #(.WIDTH(16), .ACC_WIDTH(32), .COUNT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int fails  = 0;

    // Reference model: a frame is a plain sum of its products, clipped at the
    // accumulator maximum; ovf says whether clipping happened.
    bit              m_hold   [2];
    longint unsigned m_total  [2];
    int              m_cnt    [2];
    longint unsigned m_sum    [2];
    bit              m_ovf    [2];
    int              m_frames [2];

    logic        ov, ir, o;
    logic [63:0] s;

    function automatic int cnt_of(input bit d);
        return d ? 2 : 4;
    endfunction

    function automatic longint unsigned max_of(input bit d);
        return d ? 64'h0000_0000_FFFF_FFFF : 64'h0000_00FF_FFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_hold[d]  = 1'b0;
            m_total[d] = 64'd0;
            m_cnt[d]   = 0;
        end
    endtask

    task automatic idle();
        bus4.in_valid = 1'b0; bus4.p = 32'd0; bus4.out_ready = 1'b0; bus4.clear = 1'b0;
        bus2.in_valid = 1'b0; bus2.p = 32'd0; bus2.out_ready = 1'b0; bus2.clear = 1'b0;
    endtask

    task automatic step(input bit d, input bit iv, input logic [31:0] pv,
                        input bit ordy, input bit clr);
        if (d) begin
            bus2.in_valid = iv; bus2.p = pv; bus2.out_ready = ordy; bus2.clear = clr;
        end else begin
            bus4.in_valid = iv; bus4.p = pv; bus4.out_ready = ordy; bus4.clear = clr;
        end
        if (clr) begin
            m_hold[d] = 1'b0; m_total[d] = 64'd0; m_cnt[d] = 0;
        end else if (!m_hold[d]) begin
            if (iv) begin
                m_total[d] += 64'(pv);
                m_cnt[d]++;
                if (m_cnt[d] == cnt_of(d)) begin
                    m_ovf[d]   = (m_total[d] > max_of(d));
                    m_sum[d]   = m_ovf[d] ? max_of(d) : m_total[d];
                    m_hold[d]  = 1'b1;
                    m_total[d] = 64'd0;
                    m_cnt[d]   = 0;
                end
            end
        end else if (ordy) begin
            m_hold[d] = 1'b0;
            m_frames[d]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input bit d, output logic ovo, output logic iro,
                          output logic oo, output logic [63:0] so);
        if (d) begin
            ovo = bus2.out_valid; iro = bus2.in_ready; oo = bus2.ovf; so = {32'd0, bus2.sum};
        end else begin
            ovo = bus4.out_valid; iro = bus4.in_ready; oo = bus4.ovf; so = {24'd0, bus4.sum};
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < 2; d++) begin
            sample(d[0], ov, ir, o, s);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1 || o !== 1'b0 || s !== 64'd0) begin
                fails++;
                $display("FAIL reset_values dut%0d: out_valid=%b in_ready=%b ovf=%b sum=%h, want 0/1/0/0",
                         d, ov, ir, o, s);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        sample(1'b0, ov, ir, o, s);
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", ir, ov);
        end
    endtask

    task automatic test_basic_frame();
        for (int c = 0; c < 7; c++) begin
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[0] || ir !== !m_hold[0]) begin
                fails++;
                $display("FAIL basic_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[0], !m_hold[0]);
            end
            if (m_hold[0]) begin
                checks++;
                if (s !== m_sum[0] || o !== m_ovf[0]) begin
                    fails++;
                    $display("FAIL basic_sum c%0d: sum=%0d ovf=%b, want %0d/%b", c, s, o, m_sum[0], m_ovf[0]);
                end
            end
            step(1'b0, c < 4, 32'(c + 1), 1'b1, 1'b0);
        end
        idle();
    endtask

    task automatic test_hold_bubbles();
        logic [12:0] ivp = 13'h07A5;
        logic [12:0] orp = 13'h180A;
        int          k   = 1;
        int          budget;
        for (int c = 0; c < 13; c++) begin
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[0] || ir !== !m_hold[0]) begin
                fails++;
                $display("FAIL bubble_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[0], !m_hold[0]);
            end
            if (m_hold[0]) begin
                checks++;
                if (s !== m_sum[0] || o !== m_ovf[0]) begin
                    fails++;
                    $display("FAIL bubble_hold_sum c%0d: sum=%0d ovf=%b, want %0d/%b", c, s, o, m_sum[0], m_ovf[0]);
                end
            end
            step(1'b0, ivp[c], (ivp[c] && c < 8) ? 32'(k) : $urandom, orp[c], 1'b0);
            if (ivp[c] && c < 8) k++;
        end
        budget = m_frames[0] + 6;
        for (int c = 0; c < 400 && m_frames[0] < budget; c++) begin
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[0] || ir !== !m_hold[0]) begin
                fails++;
                $display("FAIL random_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[0], !m_hold[0]);
            end
            if (m_hold[0]) begin
                checks++;
                if (s !== m_sum[0] || o !== m_ovf[0]) begin
                    fails++;
                    $display("FAIL random_sum c%0d: sum=%h ovf=%b, want %h/%b", c, s, o, m_sum[0], m_ovf[0]);
                end
            end
            step(1'b0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0, 1'b0);
        end
        checks++;
        if (m_frames[0] < budget) begin
            fails++;
            $display("FAIL random_budget: frames=%0d, want %0d", m_frames[0], budget);
        end
        idle();
    endtask

    task automatic test_saturation();
        logic [31:0] dp [6] = '{32'hFFFF0001, 32'hFFFF0001, 32'd0, 32'd1, 32'd1, 32'd0};
        logic [5:0]  ivp = 6'b011011;
        int          budget = m_frames[1] + 8;
        for (int c = 0; c < 6; c++) begin
            sample(1'b1, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[1] || ir !== !m_hold[1]) begin
                fails++;
                $display("FAIL sat_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[1], !m_hold[1]);
            end
            if (m_hold[1]) begin
                checks++;
                if (s !== m_sum[1] || o !== m_ovf[1]) begin
                    fails++;
                    $display("FAIL sat_sum c%0d: sum=%h ovf=%b, want %h/%b", c, s, o, m_sum[1], m_ovf[1]);
                end
            end
            step(1'b1, ivp[c], dp[c], 1'b1, 1'b0);
        end
        for (int c = 0; c < 200 && m_frames[1] < budget; c++) begin
            sample(1'b1, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[1] || ir !== !m_hold[1]) begin
                fails++;
                $display("FAIL sat_rand_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[1], !m_hold[1]);
            end
            if (m_hold[1]) begin
                checks++;
                if (s !== m_sum[1] || o !== m_ovf[1]) begin
                    fails++;
                    $display("FAIL sat_rand_sum c%0d: sum=%h ovf=%b, want %h/%b", c, s, o, m_sum[1], m_ovf[1]);
                end
            end
            step(1'b1, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 1'b0);
        end
        checks++;
        if (m_frames[1] < budget) begin
            fails++;
            $display("FAIL sat_budget: frames=%0d, want %0d", m_frames[1], budget);
        end
        idle();
    endtask

    task automatic test_clear();
        int          ps [16] = '{5, 5, 7, 1, 1, 1, 1, 0, 9, 0, 3, 1, 1, 1, 0, 0};
        logic [15:0] ivp = 16'h3D7F;
        logic [15:0] clp = 16'h0104;
        logic [15:0] orp = 16'h4400;
        for (int c = 0; c < 16; c++) begin
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[0] || ir !== !m_hold[0]) begin
                fails++;
                $display("FAIL clear_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[0], !m_hold[0]);
            end
            if (m_hold[0]) begin
                checks++;
                if (s !== m_sum[0] || o !== m_ovf[0]) begin
                    fails++;
                    $display("FAIL clear_sum c%0d: sum=%0d ovf=%b, want %0d/%b", c, s, o, m_sum[0], m_ovf[0]);
                end
            end
            step(1'b0, ivp[c], 32'(ps[c]), orp[c], clp[c]);
        end
        idle();
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
        for (int phase = 0; phase < 2; phase++) begin
            #1 rst_n = 1'b0;
            #1;
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1 || o !== 1'b0 || s !== 64'd0) begin
                fails++;
                $display("FAIL async_reset_p%0d: out_valid=%b in_ready=%b ovf=%b sum=%h, want 0/1/0/0",
                         phase, ov, ir, o, s);
            end
            model_reset();
            #1 rst_n = 1'b1;
            if (phase == 0) begin
                for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
                sample(1'b0, ov, ir, o, s);
                checks++;
                if (ov !== m_hold[0] || s !== m_sum[0]) begin
                    fails++;
                    $display("FAIL pre_reset_hold: out_valid=%b sum=%0d, want %b/%0d", ov, s, m_hold[0], m_sum[0]);
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[0] || ir !== !m_hold[0]) begin
                fails++;
                $display("FAIL post_reset_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[0], !m_hold[0]);
            end
            if (m_hold[0]) begin
                checks++;
                if (s !== m_sum[0] || o !== m_ovf[0]) begin
                    fails++;
                    $display("FAIL post_reset_sum c%0d: sum=%0d ovf=%b, want %0d/%b", c, s, o, m_sum[0], m_ovf[0]);
                end
            end
            step(1'b0, c < 4, 32'd2, 1'b1, 1'b0);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        int budget = m_frames[0] + 6;
        for (int c = 0; c < 100 && m_frames[0] < budget; c++) begin
            sample(1'b0, ov, ir, o, s);
            checks++;
            if (ov !== m_hold[0] || ir !== !m_hold[0]) begin
                fails++;
                $display("FAIL b2b_handshake c%0d: out_valid=%b in_ready=%b, want %b/%b",
                         c, ov, ir, m_hold[0], !m_hold[0]);
            end
            if (m_hold[0]) begin
                checks++;
                if (s !== m_sum[0] || o !== m_ovf[0]) begin
                    fails++;
                    $display("FAIL b2b_sum c%0d: sum=%h ovf=%b, want %h/%b", c, s, o, m_sum[0], m_ovf[0]);
                end
            end
            step(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
        end
        checks++;
        if (m_frames[0] < budget) begin
            fails++;
            $display("FAIL b2b_budget: frames=%0d, want %0d", m_frames[0], budget);
        end
        idle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_sum[d] = 64'd0; m_ovf[d] = 1'b0; m_frames[d] = 0;
        end
        model_reset();
        test_reset();
        test_basic_frame();
        test_hold_bubbles();
        test_saturation();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
